// File: rtl/pulse_width_meter_pkg.sv
// pulse_width_meter_pkg: shared widths, saturation limit and channel numbering
package pulse_width_meter_pkg;
  localparam int CNT_W_DEF = 10;
  localparam int NUM_W = 5;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
  function automatic logic [NUM_W-1:0] idx_to_number(input logic [NUM_W-1:0] k);
    return k + 1'b1;
  endfunction
endpackage

// File: rtl/pulse_width_meter_channel.sv
// pw_channel: one gate input; saturating high-time counter, pending result slot and sticky overwrite flag
module pw_channel
  import pulse_width_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic             sig,
  input  logic             drain_sel,
  input  logic             OVR_CLR,
  output logic             pend_vld,
  output logic [CNT_W-1:0] pend_val,
  output logic             ovr
);
  logic             sig_d;
  logic [CNT_W-1:0] cnt;
  logic             rise, high, fall;
  assign rise = sig & ~sig_d;
  assign high = sig & sig_d;
  assign fall = ~sig & sig_d;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sig_d    <= 1'b0;
      cnt      <= '0;
      pend_val <= '0;
      pend_vld <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      sig_d <= sig;
      if (rise) cnt <= {{(CNT_W-1){1'b0}}, TICK};
      else if (high && TICK && cnt != '1) cnt <= cnt + 1'b1;
      // a drain and a fresh result in the same cycle leave the new result pending
      if (fall) begin
        pend_val <= cnt;
        pend_vld <= 1'b1;
      end else if (drain_sel) pend_vld <= 1'b0;
      if (fall && pend_vld && !drain_sel) ovr <= 1'b1;
      else if (OVR_CLR) ovr <= 1'b0;
    end
  end
endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: per-channel pulse meters drained round-robin into one (T, NUMBER, EN) strobe
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic [WIDTH:0]   SIG,
  input  logic             OVR_CLR,
  output logic [CNT_W-1:0] T,
  output logic [NUM_W-1:0] NUMBER,
  output logic             EN,
  output logic [WIDTH:0]   OVR
);
  localparam logic [NUM_W:0] LAST = (NUM_W+1)'(WIDTH);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  logic [WIDTH:0]            pend_vld, drain_sel;
  logic [WIDTH:0][CNT_W-1:0] pend_val;
  logic [NUM_W-1:0]          ptr, k;
  logic [NUM_W:0]            s;
  logic                      hit;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_ch
    pw_channel #(.CNT_W(CNT_W)) u_ch (
      .CLK      (CLK),
      .RESET    (RESET),
      .TICK     (TICK),
      .sig      (SIG[i]),
      .drain_sel(drain_sel[i]),
      .OVR_CLR  (OVR_CLR),
      .pend_vld (pend_vld[i]),
      .pend_val (pend_val[i]),
      .ovr      (OVR[i])
    );
  end
  // first pending channel at or above ptr, wrapping past the last channel
  always_comb begin
    hit = 1'b0;
    k   = '0;
    s   = '0;
    for (int j = 0; j <= WIDTH; j++) begin
      s = {1'b0, ptr} + (NUM_W+1)'(j);
      s = s > LAST ? s - LAST - 1'b1 : s;
      if (!hit && pend_vld[s[NUM_W-1:0]]) begin
        hit = 1'b1;
        k   = s[NUM_W-1:0];
      end
    end
    drain_sel = hit ? ONE << k : '0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr    <= '0;
      T      <= '0;
      NUMBER <= '0;
      EN     <= 1'b0;
    end else begin
      EN     <= hit;
      T      <= hit ? pend_val[k] : '0;
      NUMBER <= hit ? idx_to_number(k) : '0;
      if (hit) ptr <= k == LAST[NUM_W-1:0] ? '0 : k + 1'b1;
    end
  end
endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
Time-multiplexed multi-channel pulse-width meter. It measures the high-time of each of WIDTH+1 synchronised gate inputs in TICK units. It then emits one measurement per cycle as a (T, NUMBER, EN) strobe to the per-channel maximum tracker directly downstream. The T, NUMBER and EN outputs are valid in the same cycle, because the downstream compare is combinational on all three.

Parameters:
WIDTH, 19, index of the highest channel; channel count is WIDTH+1 (max 31)
CNT_W, 10, measurement width; the counter saturates at 2^CNT_W-1

Ports:
CLK  in  1  single clock; all logic on the rising edge
RESET  in  1  synchronous, active-high reset
TICK  in  1  timebase enable; counters advance only when TICK=1
SIG  in  WIDTH+1  gate inputs, already synchronised to CLK
OVR_CLR  in  1  clears all OVR bits (sticky)
T  out  CNT_W  measured high-time
NUMBER  out  5  channel number, 1-based; 0 when EN=0
EN  out  1  one-cycle strobe; T and NUMBER valid
OVR  out  WIDTH+1  sticky per-channel "pending result overwritten" flag

Behaviour:
- Reset, synchronous with RESET=1 at an edge: cnt, pend_val, pend_vld, sig_d, ptr, T, NUMBER, EN and OVR all go to 0. RESET overrides every other event in the same cycle, including mid-pulse and pending results; those results are discarded.
- sig_d[j] registers SIG[j] every cycle. Because sig_d resets to 0, a channel that is high when reset releases is treated as a rising edge.
- Per-channel counter, evaluated each edge:
  - Rising edge (sig_d=0, SIG=1): cnt <= TICK ? 1 : 0.
  - High (sig_d=1, SIG=1): if TICK and cnt != max, cnt <= cnt+1. cnt saturates at 2^CNT_W-1 and never wraps.
  - Falling edge (sig_d=1, SIG=0): pend_val <= cnt and pend_vld <= 1. cnt holds its value and is unused until the next rising edge.
  - A pulse high for one cycle with TICK=0 yields T=0; this is valid and is still reported.
- Overwrite on falling edge: if pend_vld=1 already and that channel is not being drained this cycle, the new value replaces the old and OVR[j] <= 1.
- Falling edge and drain on the same channel in the same cycle: the old value goes out, the new value is stored, pend_vld stays 1, and OVR is unchanged.
- OVR_CLR=1 clears all OVR bits. If OVR_CLR and a new overwrite occur in the same cycle, the set wins.
- Round-robin drain, once per cycle:
  - Search pend_vld from index ptr upward, wrapping at WIDTH. Take the first set index k.
  - Registered outputs: T <= pend_val[k], NUMBER <= k+1, EN <= 1, pend_vld[k] <= 0, ptr <= (k==WIDTH) ? 0 : k+1.
  - If nothing is pending: EN <= 0, NUMBER <= 0, T <= 0, ptr holds.
- Latency: a falling edge sampled at edge n sets pend at edge n; EN is asserted after edge n+1 at the earliest. Worst-case wait is WIDTH+1 cycles with every channel pending.
- Throughput is 1 result/cycle. There is no back-pressure; the consumer always accepts.
- EN is never asserted for two consecutive cycles with the same NUMBER unless that channel re-pended in between.

Decomposition:
- Shared package: CNT_W default, channel-number width (5), the CNT_MAX constant, and a function idx_to_number(k) = k+1.
- One sub-module, pw_channel, replicated WIDTH+1 times in a generate loop. It holds sig_d, cnt, pend_val, pend_vld and the OVR bit. Its inputs are SIG bit, TICK, drain_sel and OVR_CLR; its outputs are pend_vld and pend_val.
- The top level contains only the round-robin arbiter, ptr and the output registers.

Test Plan:
- Reset then TICK=1 constant; SIG[0] high for 7 cycles -> exactly one EN, NUMBER=1, T=7, two cycles after SIG falls.
- SIG[3] high 2000 cycles, TICK=1 -> T=1023 (saturated), NUMBER=4, OVR=0.
- SIG[0], SIG[5] and SIG[19] fall in the same cycle with counts 3, 9 and 12, ptr=0 -> EN for three consecutive cycles with NUMBER 1, 6, 20 and T 3, 9, 12; then EN=0.
- Ptr fairness: ptr=6 after draining ch5; ch0 and ch7 pend together -> NUMBER=8 first, then 1.
- Two 1-cycle pulses on ch2 while 19 other channels are pending -> second value reported, OVR[2]=1; OVR_CLR pulse -> OVR[2]=0.
- RESET asserted mid-pulse with ch4 pending -> outputs 0 next cycle, ch4 result never emitted; SIG[4] still high at release -> counted as new pulse starting at 1.
